byte_unstriping_deskew: RTL
===========================

// Module: byte_unstriping_deskew
// PURPOSE
//  Receive-side counterpart of the byte striping stage: merges two 32-bit lanes back into a single
//  32-bit word stream in original order (lane 0 word, then lane 1 word, repeating).
//  A per-lane FIFO absorbs inter-lane skew. An alignment FSM pairs the first word of each lane.
//  Runs entirely on clk_2f, so output rate equals twice the per-lane rate.
// PARAMETERS
//  WIDTH  32  lane and output data width
//  DEPTH  4   per-lane FIFO depth in words; power of 2, >=2; max tolerated skew = DEPTH-1 words
// PORTS
//  clk_2f     in   1      single clock; all inputs sampled and all outputs updated on posedge
//  reset_L    in   1      asynchronous active-low reset
//  lane_0     in   WIDTH  lane 0 data word
//  valid_0    in   1      lane_0 holds a word this cycle
//  lane_1     in   WIDTH  lane 1 data word
//  valid_1    in   1      lane_1 holds a word this cycle
//  realign    in   1      synchronous flush-and-realign request
//  data_out   out  WIDTH  merged data word
//  valid_out  out  1      data_out holds a new word this cycle
//  aligned    out  1      FSM in RUN state
//  overflow   out  1      sticky: a lane word was dropped because its FIFO was full
// BEHAVIOUR
//  Reset: one clock, clk_2f. reset_L is asynchronous and active-low.
//   - While reset_L=0: data_out=0, valid_out=0, aligned=0, overflow=0.
//   - Both FIFOs empty, pointers 0, sel=0, FSM=ALIGN.
//   - Assertion mid-operation takes effect immediately, without waiting for a clock edge; all in-flight words are lost.
//  FIFO write:
//   - valid_x=1 writes lane_x into FIFO x at the edge.
//   - Write to a full FIFO with no pop at the same edge: word dropped, overflow<=1.
//     overflow holds until reset_L or realign.
//   - Full FIFO with pop on the same edge: write accepted, no overflow.
//   - Writes are accepted in every FSM state.
//  FSM states: ALIGN, RUN.
//   - ALIGN: valid_out<=0.
//     When both FIFOs are non-empty (pre-edge count>0): pop lane 0 head, data_out<=head, valid_out<=1, sel<=1, state<=RUN.
//   - RUN: if FIFO[sel] is non-empty: data_out<=head, valid_out<=1, pop, sel<=~sel.
//     Else valid_out<=0 and sel holds (stall, order preserved).
//   - aligned=1 exactly when state==RUN (registered).
//  Latency: a word written at edge N is poppable at edge N+1 at the earliest, and valid on data_out after that edge.
//  data_out holds its last value whenever valid_out=0.
//  realign=1 at an edge, highest priority after reset:
//   - FIFOs emptied, sel<=0, state<=ALIGN, valid_out<=0, overflow<=0.
//   - Lane words presented at that edge are discarded.
//  Pointers: log2(DEPTH)-bit, wrap modulo DEPTH. Occupancy counter: log2(DEPTH)+1 bits.
//  No combinational path from inputs to outputs.
// TESTING
//  1. Aligned lanes, both valid every 2nd cycle: lane0 A0,A1 and lane1 B0,B1 -> data_out A0,B0,A1,B1; aligned=1 from first output; overflow=0.
//  2. lane_1 lags lane_0 by 3 cycles (DEPTH=4) -> first valid_out one edge after B0 is written; order A0,B0,A1,B1,...; overflow=0.
//  3. DEPTH=4, five valid_0 words 0x1..0x5, lane 1 idle -> overflow=1 after 5th edge; 0x5 dropped; later B0 -> data_out 0x1,B0...
//  4. In RUN, lane 1 stops for 4 cycles -> valid_out=0 with sel=1 held; B resumes -> output continues with B word, no reorder.
//  5. reset_L low mid-stream, asynchronous to clk_2f -> all outputs 0 immediately; after release, fresh stream realigns as in test 1.
//  6. overflow=1 in RUN, pulse realign -> next edge: aligned=0, overflow=0, FIFOs empty; new paired words realign correctly.

Source files
------------

// File: rtl/byte_unstriping_deskew_if.sv
// Lane-side and merged-side signals of the two-lane unstriping/deskew stage.
// The master modport drives the lanes and receives the merged stream.
interface byte_unstriping_deskew_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] lane_0;
  logic             valid_0;
  logic [WIDTH-1:0] lane_1;
  logic             valid_1;
  logic             realign;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             aligned;
  logic             overflow;

  modport master (
    output lane_0, valid_0, lane_1, valid_1, realign,
    input  data_out, valid_out, aligned, overflow
  );

  modport slave (
    input  lane_0, valid_0, lane_1, valid_1, realign,
    output data_out, valid_out, aligned, overflow
  );
endinterface

// File: rtl/byte_unstriping_deskew.sv
// Merges two skewed 32-bit lanes back into one word stream (lane 0, lane 1, ...).
// Each lane has a small FIFO; an ALIGN/RUN FSM pairs the first words and then alternates.
module byte_unstriping_deskew #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic                   clk_2f,
  input logic                   reset_L,
  byte_unstriping_deskew_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {ALIGN, RUN} state_t;

  state_t           state;
  logic             sel;
  logic [WIDTH-1:0] mem_0 [DEPTH];
  logic [WIDTH-1:0] mem_1 [DEPTH];
  logic [AW-1:0]    wr_ptr_0, rd_ptr_0, wr_ptr_1, rd_ptr_1;
  logic [CW-1:0]    count_0, count_1;
  logic [WIDTH-1:0] data_q;
  logic             valid_q, aligned_q, overflow_q;
  logic             has_0, has_1, full_0, full_1;
  logic             pop_0, pop_1, push_0, push_1, drop;

  // A full FIFO still accepts a write when its head leaves at the same edge.
  always_comb begin
    has_0  = (count_0 != '0);
    has_1  = (count_1 != '0);
    full_0 = (count_0 == CW'(DEPTH));
    full_1 = (count_1 == CW'(DEPTH));
    pop_0  = 1'b0;
    pop_1  = 1'b0;
    if (state == ALIGN) begin
      pop_0 = has_0 && has_1;
    end else if (!sel) begin
      pop_0 = has_0;
    end else begin
      pop_1 = has_1;
    end
    push_0 = bus.valid_0 && (!full_0 || pop_0);
    push_1 = bus.valid_1 && (!full_1 || pop_1);
    drop   = (bus.valid_0 && !push_0) || (bus.valid_1 && !push_1);
  end

  always_ff @(posedge clk_2f) begin
    if (push_0 && !bus.realign) mem_0[wr_ptr_0] <= bus.lane_0;
    if (push_1 && !bus.realign) mem_1[wr_ptr_1] <= bus.lane_1;
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state      <= ALIGN;
      sel        <= 1'b0;
      wr_ptr_0   <= '0;
      rd_ptr_0   <= '0;
      wr_ptr_1   <= '0;
      rd_ptr_1   <= '0;
      count_0    <= '0;
      count_1    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      aligned_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.realign) begin
      state      <= ALIGN;
      sel        <= 1'b0;
      wr_ptr_0   <= '0;
      rd_ptr_0   <= '0;
      wr_ptr_1   <= '0;
      rd_ptr_1   <= '0;
      count_0    <= '0;
      count_1    <= '0;
      valid_q    <= 1'b0;
      aligned_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_0) wr_ptr_0 <= wr_ptr_0 + AW'(1);
      if (push_1) wr_ptr_1 <= wr_ptr_1 + AW'(1);
      if (pop_0)  rd_ptr_0 <= rd_ptr_0 + AW'(1);
      if (pop_1)  rd_ptr_1 <= rd_ptr_1 + AW'(1);
      count_0    <= count_0 + CW'(push_0) - CW'(pop_0);
      count_1    <= count_1 + CW'(push_1) - CW'(pop_1);
      overflow_q <= overflow_q | drop;

      // An empty FIFO on the selected lane stalls with sel held, so order is kept.
      case (state)
        ALIGN: begin
          if (pop_0) begin
            data_q    <= mem_0[rd_ptr_0];
            valid_q   <= 1'b1;
            sel       <= 1'b1;
            state     <= RUN;
            aligned_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
        end
        RUN: begin
          if (pop_0 || pop_1) begin
            data_q  <= sel ? mem_1[rd_ptr_1] : mem_0[rd_ptr_0];
            valid_q <= 1'b1;
            sel     <= ~sel;
          end else begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          state     <= ALIGN;
          valid_q   <= 1'b0;
          aligned_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.aligned   = aligned_q;
  assign bus.overflow  = overflow_q;
endmodule
